reveal_engine: RTL and testbench
================================

Name: reveal_engine

Overview:
- Sequential producer of the shown-map that the end-condition checker consumes.
- On a click, reveals the selected cell. If that cell is a zero-count cell, it flood-fills outward through neighbouring cells.
- Uses an explicit LIFO of cell indices and examines one neighbour per cycle.
- Sits between the input/cursor logic and the end-condition and display blocks.

Parameters:
- MAP_WIDTH, 10, columns.
- MAP_HEIGHT, 10, rows.
- MAP_CELL_LENGTH, 4, bits per cell. Values 0..8 are the neighbour-mine count.
- IS_MINE, 4'd9, cell code for a mine.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous clear of the shown map; aborts any operation
- start_i  in  1  click pulse; sampled only in IDLE
- row_i  in  clog2(MAP_HEIGHT)  click row
- col_i  in  clog2(MAP_WIDTH)  click column
- map_i  in  MAP_CELL_LENGTH*MAP_HEIGHT*MAP_WIDTH  packed game map; cell p at bits [p*MAP_CELL_LENGTH +: MAP_CELL_LENGTH], p = row*MAP_WIDTH+col
- map_flag_i  in  MAP_HEIGHT*MAP_WIDTH  1 = cell flagged
- map_shown_o  out  MAP_HEIGHT*MAP_WIDTH  registered shown map; 1 = shown
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse when a click finishes

Behaviour:
- Reset (async, rst_n=0): map_shown_o=0, busy_o=0, done_o=0, stack empty, state IDLE.
- clear_i has priority over everything. On the next edge: map_shown_o=0, stack emptied, state IDLE, no done_o pulse.
- IDLE
  - start_i=1: latch index cur=row_i*MAP_WIDTH+col_i and go to CHECK.
  - start_i is ignored in every other state.
- CHECK
  - Out-of-range row/col, flagged cell, or already-shown cell: no change, go to DONE.
  - Otherwise set shown[cur].
  - If value==0: push cur, go to POP. Otherwise go to DONE (mine case: see Optional Feature).
- POP
  - Stack empty: go to DONE.
  - Otherwise pop into cur, set nbr=0, go to NBR.
- NBR (8 cycles, nbr 0..7, order NW,N,NE,W,E,SW,S,SE)
  - The neighbour qualifies if it is in bounds, not shown, not flagged, and not IS_MINE.
  - Qualifying neighbour: set its shown bit in the same cycle; push it if its value==0.
  - At nbr==7 go to POP.
- DONE: done_o=1 for exactly one cycle, then IDLE. busy_o falls together with done_o.
- Uniqueness: a cell is marked shown at push time, so each index is pushed at most once. Stack depth MAP_WIDTH*MAP_HEIGHT can never overflow.
- Push and pop are never in the same cycle.
- Latency
  - Single-cell or no-op click: done_o is high in the 2nd cycle after the start edge.
  - Flood fill: 2 + 9*(cells pushed) + 1 cycles.
- Bounds: edge and corner neighbours are discarded by row/col comparisons, never by index wrap. For example, col 0 has no W, NW or SW neighbour.
- map_i and map_flag_i must stay stable while busy_o=1. Flag changes made during a fill are not required to be honoured.

Optional Feature:
- Macro: REVEAL_ALL_MINES_EN.
- Defined: a mine click in CHECK sets shown[cur] and goes to state MINES. MINES ORs in the shown bit of every IS_MINE cell in one cycle, then goes to DONE. Mine-click done latency becomes 3 cycles.
- Undefined: only the clicked mine is shown; done at 2 cycles. The MINES state is absent.

Decomposition:
- Shared package/header:
  - Map dimensions, MAP_CELL_LENGTH, IS_MINE.
  - Index width IDX_W = clog2(MAP_WIDTH*MAP_HEIGHT).
  - State encodings IDLE/CHECK/POP/NBR/DONE/MINES.
  - Neighbour offset order.
- Sub-module reveal_stack:
  - Parameterised LIFO with depth and width parameters.
  - Ports: push/pop/data in and out/empty/clear.
  - Synchronous write, registered pointer.

Test Plan (bench overrides MAP_WIDTH=MAP_HEIGHT=4; cell p = row*4+col):
- Reset: hold rst_n=0 mid-simulation -> map_shown_o=16'h0, busy_o=0, done_o=0 immediately (asynchronous).
- Cell (1,1) value 2, pulse start -> after 2 cycles done_o=1, map_shown_o=16'h0020, busy_o=0.
- Single mine at (3,3), all other cells correct counts; click (0,0) -> map_shown_o=16'h7FFF, bit 15 clear; done_o once, at cycle 2+9*12+1=111 after start (12 zero cells pushed).
- Click mine (3,3) -> without macro map_shown_o=16'h8000, done at 2 cycles; with REVEAL_ALL_MINES_EN, a second mine at (0,3) also yields 16'h8008, done at 3 cycles.
- Flagged cell (2,0), or a repeat click on a shown cell -> map_shown_o unchanged, done_o at 2 cycles; a start_i pulse while busy_o=1 produces no extra done_o.
- clear_i asserted at cycle 20 of a flood fill -> next cycle map_shown_o=0, busy_o=0, no done_o; a fresh click afterwards behaves normally.

Source files
------------

// File: rtl/reveal_engine_pkg.sv
// reveal_engine_pkg: shared constants, FSM state encoding and neighbour
// scan order for the reveal engine.
// Optional feature macro: REVEAL_ALL_MINES_EN (adds the MINES state).
package reveal_engine_pkg;

  localparam int DEF_MAP_WIDTH       = 10;
  localparam int DEF_MAP_HEIGHT      = 10;
  localparam int DEF_MAP_CELL_LENGTH = 4;
  localparam logic [3:0] DEF_IS_MINE = 4'd9;
  localparam int IDX_W = $clog2(DEF_MAP_WIDTH * DEF_MAP_HEIGHT);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    POP,
    NBR,
    DONE
`ifdef REVEAL_ALL_MINES_EN
    , MINES
`endif
  } state_t;

  // Neighbour order 0..7 is NW, N, NE, W, E, SW, S, SE.
  function automatic int nbr_drow(input logic [2:0] k);
    case (k)
      3'd0, 3'd1, 3'd2: return -1;
      3'd3, 3'd4:       return 0;
      default:          return 1;
    endcase
  endfunction

  function automatic int nbr_dcol(input logic [2:0] k);
    case (k)
      3'd0, 3'd3, 3'd5: return -1;
      3'd1, 3'd6:       return 0;
      default:          return 1;
    endcase
  endfunction

endpackage

// File: rtl/reveal_stack.sv
// reveal_stack: LIFO of cell indices used by the flood fill. Synchronous
// write, registered pointer, top-of-stack visible combinationally.
module reveal_stack #(
  parameter int DEPTH = 100,
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o
);

  localparam int PTR_W  = $clog2(DEPTH + 1);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              full;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] top_addr;

  // Pointer update and address decode; clear empties the stack at once
  always_comb begin
    full     = (ptr_q == PTR_W'(DEPTH));
    empty_o  = (ptr_q == '0);
    wr_addr  = full ? '0 : ADDR_W'(ptr_q);
    top_addr = empty_o ? '0 : ADDR_W'(ptr_q - 1'b1);
    data_o   = mem_q[top_addr];
    ptr_d    = ptr_q;
    if (clear_i) begin
      ptr_d = '0;
    end else if (push_i && !full) begin
      ptr_d = ptr_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      ptr_d = ptr_q - 1'b1;
    end
  end

  // Pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Storage write; contents need no reset since the pointer guards reads
  always_ff @(posedge clk) begin
    if (push_i && !clear_i && !full) begin
      mem_q[wr_addr] <= data_i;
    end
  end

endmodule

// File: rtl/reveal_engine.sv
// reveal_engine: reveals a clicked cell and flood-fills zero-count regions
// using an explicit stack, examining one neighbour per cycle.
// Optional feature macro: REVEAL_ALL_MINES_EN (mine click shows every mine).
module reveal_engine
  import reveal_engine_pkg::*;
#(
  parameter int MAP_WIDTH       = DEF_MAP_WIDTH,
  parameter int MAP_HEIGHT      = DEF_MAP_HEIGHT,
  parameter int MAP_CELL_LENGTH = DEF_MAP_CELL_LENGTH,
  parameter logic [MAP_CELL_LENGTH-1:0] IS_MINE = MAP_CELL_LENGTH'(DEF_IS_MINE),
  localparam int NCELLS = MAP_WIDTH * MAP_HEIGHT,
  localparam int ROW_W  = (MAP_HEIGHT > 1) ? $clog2(MAP_HEIGHT) : 1,
  localparam int COL_W  = (MAP_WIDTH > 1) ? $clog2(MAP_WIDTH) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   clear_i,
  input  logic                                   start_i,
  input  logic [ROW_W-1:0]                       row_i,
  input  logic [COL_W-1:0]                       col_i,
  input  logic [MAP_CELL_LENGTH*NCELLS-1:0]      map_i,
  input  logic [NCELLS-1:0]                      map_flag_i,
  output logic [NCELLS-1:0]                      map_shown_o,
  output logic                                   busy_o,
  output logic                                   done_o
);

  localparam int CELL_IDX_W = (NCELLS > 1) ? $clog2(NCELLS) : 1;

  state_t                     state_q, state_d;
  logic [ROW_W-1:0]           row_q, row_d;
  logic [COL_W-1:0]           col_q, col_d;
  logic [2:0]                 nbr_q, nbr_d;
  logic [NCELLS-1:0]          shown_q, shown_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic                       cur_in_range;
  logic [CELL_IDX_W-1:0]      cur_idx;
  logic [MAP_CELL_LENGTH-1:0] cur_val;

  int                         nbr_row, nbr_col;
  logic                       nbr_inb, nbr_ok;
  logic [CELL_IDX_W-1:0]      nbr_idx;
  logic [MAP_CELL_LENGTH-1:0] nbr_val;

  logic                       push, pop, stack_empty;
  logic [CELL_IDX_W-1:0]      push_data, stack_top;

  reveal_stack #(
    .DEPTH (NCELLS),
    .WIDTH (CELL_IDX_W)
  ) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (push_data),
    .data_o  (stack_top),
    .empty_o (stack_empty)
  );

  // Current cell decode; out-of-range coordinates map to index 0 but are never acted on
  always_comb begin
    cur_in_range = (int'(row_q) < MAP_HEIGHT) && (int'(col_q) < MAP_WIDTH);
    cur_idx      = cur_in_range ? CELL_IDX_W'(int'(row_q) * MAP_WIDTH + int'(col_q)) : '0;
    cur_val      = map_i[cur_idx*MAP_CELL_LENGTH +: MAP_CELL_LENGTH];
  end

  // Neighbour decode; edges are rejected by row/col comparison, never by index wrap
  always_comb begin
    nbr_row = int'(row_q) + nbr_drow(nbr_q);
    nbr_col = int'(col_q) + nbr_dcol(nbr_q);
    nbr_inb = (nbr_row >= 0) && (nbr_row < MAP_HEIGHT) &&
              (nbr_col >= 0) && (nbr_col < MAP_WIDTH);
    nbr_idx = nbr_inb ? CELL_IDX_W'(nbr_row * MAP_WIDTH + nbr_col) : '0;
    nbr_val = map_i[nbr_idx*MAP_CELL_LENGTH +: MAP_CELL_LENGTH];
    nbr_ok  = nbr_inb && !shown_q[nbr_idx] && !map_flag_i[nbr_idx] && (nbr_val != IS_MINE);
  end

`ifdef REVEAL_ALL_MINES_EN
  logic [NCELLS-1:0] mine_mask;

  // Mask of every mine cell, ORed into the shown map in one cycle
  always_comb begin
    mine_mask = '0;
    for (int p = 0; p < NCELLS; p++) begin
      mine_mask[p] = (map_i[p*MAP_CELL_LENGTH +: MAP_CELL_LENGTH] == IS_MINE);
    end
  end
`endif

  // Next-state logic; cells are marked shown when pushed so none is pushed twice
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    nbr_d     = nbr_q;
    shown_d   = shown_q;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = cur_idx;
    if (clear_i) begin
      state_d = IDLE;
      shown_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            row_d   = row_i;
            col_d   = col_i;
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (!cur_in_range || map_flag_i[cur_idx] || shown_q[cur_idx]) begin
            state_d = DONE;
          end else begin
            shown_d[cur_idx] = 1'b1;
            if (cur_val == '0) begin
              push    = 1'b1;
              state_d = POP;
`ifdef REVEAL_ALL_MINES_EN
            end else if (cur_val == IS_MINE) begin
              state_d = MINES;
`endif
            end else begin
              state_d = DONE;
            end
          end
        end
        POP: begin
          if (stack_empty) begin
            state_d = DONE;
          end else begin
            pop     = 1'b1;
            row_d   = ROW_W'(int'(stack_top) / MAP_WIDTH);
            col_d   = COL_W'(int'(stack_top) % MAP_WIDTH);
            nbr_d   = 3'd0;
            state_d = NBR;
          end
        end
        NBR: begin
          if (nbr_ok) begin
            shown_d[nbr_idx] = 1'b1;
            if (nbr_val == '0) begin
              push      = 1'b1;
              push_data = nbr_idx;
            end
          end
          nbr_d = nbr_q + 3'd1;
          if (nbr_q == 3'd7) begin
            state_d = POP;
          end
        end
`ifdef REVEAL_ALL_MINES_EN
        MINES: begin
          shown_d = shown_q | mine_mask;
          state_d = DONE;
        end
`endif
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      nbr_q   <= '0;
      shown_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      nbr_q   <= nbr_d;
      shown_q <= shown_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign map_shown_o = shown_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_reveal_engine.sv
// tb_reveal_engine: directed self-checking bench for reveal_engine on a 4x4 map.
// Honours REVEAL_ALL_MINES_EN when the design is built with it.
module tb_reveal_engine;

  logic        clk;
  logic        rst_n;
  logic        clear_i;
  logic        start_i;
  logic [1:0]  row_i;
  logic [1:0]  col_i;
  logic [63:0] map_i;
  logic [15:0] map_flag_i;
  logic [15:0] map_shown_o;
  logic        busy_o;
  logic        done_o;

  int tests_run;
  int tests_failed;
  int done_total;

  reveal_engine #(
    .MAP_WIDTH  (4),
    .MAP_HEIGHT (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (clear_i),
    .start_i     (start_i),
    .row_i       (row_i),
    .col_i       (col_i),
    .map_i       (map_i),
    .map_flag_i  (map_flag_i),
    .map_shown_o (map_shown_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count every done_o pulse seen away from the active edge
  always @(negedge clk) begin
    if (done_o === 1'b1) done_total++;
  end

  // Single mine at (3,3): its three neighbours count 1, all else 0
  function automatic logic [63:0] flood_map();
    logic [63:0] m;
    m = '0;
    m[15*4 +: 4] = 4'd9;
    m[10*4 +: 4] = 4'd1;
    m[11*4 +: 4] = 4'd1;
    m[14*4 +: 4] = 4'd1;
    return m;
  endfunction

  task automatic do_clear();
    @(negedge clk);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
  endtask

  // Returns at the negedge following the start edge (cycle 1)
  task automatic click(input logic [1:0] r, input logic [1:0] c);
    @(negedge clk);
    row_i   = r;
    col_i   = c;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int lat);
    lat = 1;
    while (done_o !== 1'b1 && lat < limit) begin
      @(negedge clk);
      lat++;
    end
    if (done_o !== 1'b1) begin
      $display("[TB] FAIL done_timeout: no done_o within %0d cycles", limit);
      tests_failed++;
      tests_run++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests_run++;
    if (map_shown_o !== 16'h0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      $display("[TB] FAIL reset_state: shown=%h busy=%b done=%b, want 0000/0/0",
               map_shown_o, busy_o, done_o);
      tests_failed++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int lat;
    do_clear();
    map_i = {16{4'd1}};
    map_i[5*4 +: 4] = 4'd2;
    click(2'd1, 2'd1);
    wait_done(20, lat);
    tests_run++;
    if (lat !== 2) begin
      $display("[TB] FAIL single_latency: got %0d, want 2", lat);
      tests_failed++;
    end
    tests_run++;
    if (map_shown_o !== 16'h0020) begin
      $display("[TB] FAIL single_shown: got %h, want 0020", map_shown_o);
      tests_failed++;
    end
    @(negedge clk);
    tests_run++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      $display("[TB] FAIL single_idle: busy=%b done=%b, want 0/0", busy_o, done_o);
      tests_failed++;
    end
  endtask

  task automatic test_flood();
    int lat;
    int snap;
    do_clear();
    map_i = flood_map();
    snap  = done_total;
    click(2'd0, 2'd0);
    wait_done(200, lat);
    tests_run++;
    if (lat !== 111) begin
      $display("[TB] FAIL flood_latency: got %0d, want 111", lat);
      tests_failed++;
    end
    tests_run++;
    if (map_shown_o !== 16'h7FFF) begin
      $display("[TB] FAIL flood_shown: got %h, want 7fff", map_shown_o);
      tests_failed++;
    end
    repeat (4) @(negedge clk);
    tests_run++;
    if (done_total - snap !== 1) begin
      $display("[TB] FAIL flood_done_count: got %0d, want 1", done_total - snap);
      tests_failed++;
    end
    tests_run++;
    if (busy_o !== 1'b0) begin
      $display("[TB] FAIL flood_busy: got %b, want 0", busy_o);
      tests_failed++;
    end
  endtask

  task automatic test_repeat_click();
    int lat;
    click(2'd1, 2'd1);
    wait_done(20, lat);
    tests_run++;
    if (lat !== 2 || map_shown_o !== 16'h7FFF) begin
      $display("[TB] FAIL repeat_click: lat=%0d shown=%h, want 2/7fff", lat, map_shown_o);
      tests_failed++;
    end
  endtask

  task automatic test_flagged();
    int lat;
    do_clear();
    map_i      = flood_map();
    map_flag_i = 16'h0100;
    click(2'd2, 2'd0);
    wait_done(20, lat);
    tests_run++;
    if (lat !== 2 || map_shown_o !== 16'h0000) begin
      $display("[TB] FAIL flagged_click: lat=%0d shown=%h, want 2/0000", lat, map_shown_o);
      tests_failed++;
    end
    @(negedge clk);
    map_flag_i = 16'h0000;
  endtask

  task automatic test_busy_ignore();
    int snap;
    do_clear();
    map_i = flood_map();
    snap  = done_total;
    click(2'd0, 2'd0);
    repeat (5) @(negedge clk);
    row_i   = 2'd1;
    col_i   = 2'd1;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (150) @(negedge clk);
    tests_run++;
    if (done_total - snap !== 1) begin
      $display("[TB] FAIL busy_start_done_count: got %0d, want 1", done_total - snap);
      tests_failed++;
    end
    tests_run++;
    if (map_shown_o !== 16'h7FFF) begin
      $display("[TB] FAIL busy_start_shown: got %h, want 7fff", map_shown_o);
      tests_failed++;
    end
  endtask

  task automatic test_mine();
    int lat;
    int want_lat;
    logic [15:0] want_shown;
    do_clear();
    map_i = {16{4'd1}};
    map_i[3*4 +: 4]  = 4'd9;
    map_i[15*4 +: 4] = 4'd9;
`ifdef REVEAL_ALL_MINES_EN
    want_lat   = 3;
    want_shown = 16'h8008;
`else
    want_lat   = 2;
    want_shown = 16'h8000;
`endif
    click(2'd3, 2'd3);
    wait_done(20, lat);
    tests_run++;
    if (lat !== want_lat) begin
      $display("[TB] FAIL mine_latency: got %0d, want %0d", lat, want_lat);
      tests_failed++;
    end
    tests_run++;
    if (map_shown_o !== want_shown) begin
      $display("[TB] FAIL mine_shown: got %h, want %h", map_shown_o, want_shown);
      tests_failed++;
    end
  endtask

  task automatic test_clear();
    int lat;
    int snap;
    do_clear();
    map_i = flood_map();
    click(2'd0, 2'd0);
    repeat (19) @(negedge clk);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    snap    = done_total;
    tests_run++;
    if (map_shown_o !== 16'h0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      $display("[TB] FAIL clear_abort: shown=%h busy=%b done=%b, want 0000/0/0",
               map_shown_o, busy_o, done_o);
      tests_failed++;
    end
    repeat (120) @(negedge clk);
    tests_run++;
    if (done_total - snap !== 0 || map_shown_o !== 16'h0) begin
      $display("[TB] FAIL clear_quiet: dones=%0d shown=%h, want 0/0000",
               done_total - snap, map_shown_o);
      tests_failed++;
    end
    click(2'd3, 2'd2);
    wait_done(20, lat);
    tests_run++;
    if (lat !== 2 || map_shown_o !== 16'h4000) begin
      $display("[TB] FAIL clear_then_click: lat=%0d shown=%h, want 2/4000", lat, map_shown_o);
      tests_failed++;
    end
  endtask

  task automatic test_async_reset();
    do_clear();
    map_i = flood_map();
    click(2'd0, 2'd0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (map_shown_o !== 16'h0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      $display("[TB] FAIL async_reset: shown=%h busy=%b done=%b, want 0000/0/0",
               map_shown_o, busy_o, done_o);
      tests_failed++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Test sequence
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    done_total   = 0;
    clear_i      = 1'b0;
    start_i      = 1'b0;
    row_i        = '0;
    col_i        = '0;
    map_i        = '0;
    map_flag_i   = '0;
    test_reset();
    test_single();
    test_flood();
    test_repeat_click();
    test_flagged();
    test_busy_ignore();
    test_mine();
    test_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
